// File: rtl/bubble_sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bubble_sort_pkg
//  Purpose  : Shared types and constants for the bubble sort engine
//  Revision : 1.0  initial release
// ============================================================================
package bubble_sort_pkg;

    // Engine control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        DONE = 2'd3
    } sort_state_t;

    // Sort direction selectors for the DESCENDING parameter
    localparam bit SORT_ASC  = 1'b0;
    localparam bit SORT_DESC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bubble_sort_engine_cmp_swap.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_swap
//  Purpose  : Combinational compare-exchange of one adjacent element pair.
//             lo_o goes to the lower index, hi_o to the upper index.
//  Revision : 1.0  initial release
// ============================================================================
module cmp_swap #(
    parameter int WIDTH      = 4,
    parameter bit DESCENDING = 1'b0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             swap_o
);

    // Strict comparison only, so equal values keep their order (stable sort)
    always_comb begin
        swap_o = DESCENDING ? (a_i < b_i) : (a_i > b_i);
        lo_o   = swap_o ? b_i : a_i;
        hi_o   = swap_o ? a_i : b_i;
    end

endmodule
`default_nettype wire

// File: rtl/bubble_sort_engine.sv
`default_nettype none
// ============================================================================
//  Module   : bubble_sort_engine
//  Purpose  : Serially loads DEPTH words, then bubble-sorts them in place with
//             one compare-swap per cycle and early exit on a swap-free pass.
//  Revision : 1.0  initial release
// ============================================================================
module bubble_sort_engine
    import bubble_sort_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter bit DESCENDING = SORT_ASC
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   write,
    input  logic [WIDTH-1:0]                       writedata,
    input  logic [$clog2(DEPTH)-1:0]               rd_idx,
    output logic [WIDTH-1:0]                       rd_data,
    output logic [DEPTH*WIDTH-1:0]                 data_flat,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(DEPTH*(DEPTH-1)/2+1)-1:0] swap_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH*(DEPTH-1)/2+1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH-1);
    localparam logic [PTR_W-1:0] LAST_PASS = PTR_W'(DEPTH-2);

    if (DEPTH < 2) begin : g_depth_check
        $error("bubble_sort_engine: DEPTH must be at least 2");
    end
    if (WIDTH < 1) begin : g_width_check
        $error("bubble_sort_engine: WIDTH must be at least 1");
    end

    sort_state_t             state_q, state_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [WIDTH-1:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        pass_q, pass_d;
    logic [PTR_W-1:0]        j_q, j_d;
    logic [CNT_W-1:0]        swap_count_q, swap_count_d;
    logic                    flag_q, flag_d;
    logic                    busy_q, done_q;

    logic [PTR_W-1:0]        w_j_next;
    logic [WIDTH-1:0]        w_lo, w_hi;
    logic                    w_swap;

    assign w_j_next = j_q + 1'b1;

    cmp_swap #(
        .WIDTH      (WIDTH),
        .DESCENDING (DESCENDING)
    ) u_cmp_swap (
        .a_i    (mem_q[j_q]),
        .b_i    (mem_q[w_j_next]),
        .lo_o   (w_lo),
        .hi_o   (w_hi),
        .swap_o (w_swap)
    );

    // Next-state, array update and counter control
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        pass_d       = pass_q;
        j_d          = j_q;
        swap_count_d = swap_count_q;
        flag_d       = flag_q;
        case (state_q)
            IDLE: begin
                if (write) begin
                    mem_d[0] = writedata;
                    wr_ptr_d = PTR_W'(1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (write) begin
                    mem_d[wr_ptr_q] = writedata;
                    if (wr_ptr_q == LAST_SLOT) begin
                        // Pointer holds at the last slot rather than wrapping
                        state_d      = SORT;
                        j_d          = '0;
                        pass_d       = '0;
                        swap_count_d = '0;
                        flag_d       = 1'b0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            SORT: begin
                mem_d[j_q]      = w_lo;
                mem_d[w_j_next] = w_hi;
                if (w_swap) begin
                    swap_count_d = swap_count_q + 1'b1;
                    flag_d       = 1'b1;
                end
                if (j_q == LAST_PASS - pass_q) begin
                    // End of pass: stop on a clean pass or after the final pass
                    if (!(flag_q || w_swap) || (pass_q == LAST_PASS)) begin
                        state_d = DONE;
                    end else begin
                        pass_d = pass_q + 1'b1;
                        j_d    = '0;
                        flag_d = 1'b0;
                    end
                end else begin
                    j_d = w_j_next;
                end
            end
            DONE: begin
                if (write) begin
                    mem_d[0]     = writedata;
                    wr_ptr_d     = PTR_W'(1);
                    swap_count_d = '0;
                    state_d      = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, array and counter registers; status flags registered from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            pass_q       <= '0;
            j_q          <= '0;
            swap_count_q <= '0;
            flag_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            pass_q       <= pass_d;
            j_q          <= j_d;
            swap_count_q <= swap_count_d;
            flag_q       <= flag_d;
            busy_q       <= (state_d == SORT);
            done_q       <= (state_d == DONE);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign data_flat[i*WIDTH +: WIDTH] = mem_q[i];
    end

    // Indices past DEPTH only exist when DEPTH is not a power of two
    if ((1 << PTR_W) == DEPTH) begin : g_rd_pow2
        assign rd_data = mem_q[rd_idx];
    end else begin : g_rd_guard
        assign rd_data = (32'(rd_idx) < DEPTH) ? mem_q[rd_idx] : '0;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign swap_count = swap_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bubble_sort_engine
//  Purpose  : Scoreboard bench for bubble_sort_engine, ascending (A) and
//             descending (B) instances, WIDTH=4, DEPTH=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bubble_sort_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_a, write_b;
    logic [3:0]  wd_a, wd_b;
    logic [1:0]  rd_idx_a, rd_idx_b;
    logic [3:0]  rd_data_a, rd_data_b;
    logic [15:0] flat_a, flat_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [2:0]  sc_a, sc_b;

    always #5 clk = ~clk;

    bubble_sort_engine #(.WIDTH(4), .DEPTH(4), .DESCENDING(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .write(write_a), .writedata(wd_a),
        .rd_idx(rd_idx_a), .rd_data(rd_data_a), .data_flat(flat_a),
        .busy(busy_a), .done(done_a), .swap_count(sc_a)
    );

    bubble_sort_engine #(.WIDTH(4), .DEPTH(4), .DESCENDING(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .write(write_b), .writedata(wd_b),
        .rd_idx(rd_idx_b), .rd_data(rd_data_b), .data_flat(flat_b),
        .busy(busy_b), .done(done_b), .swap_count(sc_b)
    );

    typedef struct {
        logic [15:0] flat;
        logic [2:0]  sc;
        int          busy_cycles;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor A: on each rising done, compare against the oldest expectation
    int   busy_cnt_a = 0;
    logic done_prev_a = 1'b0;
    exp_t e_a;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt_a  = 0;
            done_prev_a = 1'b0;
        end else begin
            if (busy_a) busy_cnt_a++;
            if (done_a && !done_prev_a) begin
                if (q_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done_a actual=1 expected=0");
                end else begin
                    e_a = q_a.pop_front();
                    check("A_data_flat",  32'(flat_a),     32'(e_a.flat));
                    check("A_swap_count", 32'(sc_a),       32'(e_a.sc));
                    check("A_busy_cycles", 32'(busy_cnt_a), 32'(e_a.busy_cycles));
                end
                busy_cnt_a = 0;
            end
            done_prev_a = done_a;
        end
    end

    // Monitor B: same scheme for the descending instance
    int   busy_cnt_b = 0;
    logic done_prev_b = 1'b0;
    exp_t e_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt_b  = 0;
            done_prev_b = 1'b0;
        end else begin
            if (busy_b) busy_cnt_b++;
            if (done_b && !done_prev_b) begin
                if (q_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done_b actual=1 expected=0");
                end else begin
                    e_b = q_b.pop_front();
                    check("B_data_flat",  32'(flat_b),     32'(e_b.flat));
                    check("B_swap_count", 32'(sc_b),       32'(e_b.sc));
                    check("B_busy_cycles", 32'(busy_cnt_b), 32'(e_b.busy_cycles));
                end
                busy_cnt_b = 0;
            end
            done_prev_b = done_b;
        end
    end

    task automatic push_exp(input bit sel, input logic [15:0] flat, input logic [2:0] sc, input int bc);
        exp_t e;
        e.flat = flat; e.sc = sc; e.busy_cycles = bc;
        if (sel) q_b.push_back(e); else q_a.push_back(e);
    endtask

    task automatic do_write(input bit sel, input logic [3:0] v);
        @(posedge clk); #1;
        if (sel) begin write_b = 1'b1; wd_b = v; end
        else     begin write_a = 1'b1; wd_a = v; end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        write_a = 1'b0;
        write_b = 1'b0;
    endtask

    task automatic load4(input bit sel, input logic [3:0] e0, input logic [3:0] e1,
                         input logic [3:0] e2, input logic [3:0] e3);
        do_write(sel, e0);
        do_write(sel, e1);
        do_write(sel, e2);
        do_write(sel, e3);
        idle_cycle();
    endtask

    task automatic wait_done(input bit sel, input string name);
        int n = 0;
        while (!(sel ? done_b : done_a) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? done_b : done_a)) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=done_low expected=done_high", name);
        end
    endtask

    task automatic check_rd(input bit sel, input logic [15:0] flat);
        for (int i = 0; i < 4; i++) begin
            if (sel) rd_idx_b = 2'(i); else rd_idx_a = 2'(i);
            #1;
            check(sel ? "B_rd_data" : "A_rd_data",
                  32'(sel ? rd_data_b : rd_data_a), 32'(flat[i*4 +: 4]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        write_a = 1'b0; write_b = 1'b0;
        wd_a = '0; wd_b = '0;
        rd_idx_a = '0; rd_idx_b = '0;

        // Reset state
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_done_a", 32'(done_a), 0);
        check("rst_flat_a", 32'(flat_a), 0);
        check("rst_sc_a",   32'(sc_a),   0);
        check("rst_flat_b", 32'(flat_b), 0);
        check("rst_done_b", 32'(done_b), 0);
        check_rd(1'b0, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reverse-ordered input: full six-cycle sort
        push_exp(1'b0, 16'h4321, 3'd6, 6);
        load4(1'b0, 4'd4, 4'd3, 4'd2, 4'd1);
        wait_done(1'b0, "reverse");
        check_rd(1'b0, 16'h4321);

        // Already sorted: early exit after one pass
        push_exp(1'b0, 16'h4321, 3'd0, 3);
        load4(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        wait_done(1'b0, "sorted");

        // Duplicates: equal 7s never exchanged
        push_exp(1'b0, 16'h7720, 3'd4, 6);
        load4(1'b0, 4'd7, 4'd2, 4'd7, 4'd0);
        wait_done(1'b0, "dups");
        check_rd(1'b0, 16'h7720);

        // Writes during SORT are ignored
        push_exp(1'b0, 16'h4321, 3'd6, 6);
        load4(1'b0, 4'd4, 4'd3, 4'd2, 4'd1);
        do_write(1'b0, 4'hF);
        do_write(1'b0, 4'hF);
        do_write(1'b0, 4'hF);
        idle_cycle();
        wait_done(1'b0, "sort_writes");

        // Reset in the middle of a sort
        load4(1'b0, 4'd4, 4'd3, 4'd2, 4'd1);
        @(posedge clk);
        @(negedge clk);
        check("midsort_busy_before", 32'(busy_a), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("midsort_rst_busy", 32'(busy_a), 0);
        check("midsort_rst_done", 32'(done_a), 0);
        check("midsort_rst_flat", 32'(flat_a), 0);
        check("midsort_rst_sc",   32'(sc_a),   0);
        @(posedge clk); #1 rst_n = 1'b1;

        push_exp(1'b0, 16'h4321, 3'd6, 6);
        load4(1'b0, 4'd4, 4'd3, 4'd2, 4'd1);
        wait_done(1'b0, "reload");

        // Descending instance
        push_exp(1'b1, 16'h1234, 3'd6, 6);
        load4(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        wait_done(1'b1, "desc");
        check_rd(1'b1, 16'h1234);

        // New batch from DONE
        do_write(1'b1, 4'd9);
        idle_cycle();
        @(negedge clk);
        check("newbatch_done", 32'(done_b), 0);
        check("newbatch_busy", 32'(busy_b), 0);
        check("newbatch_flat", 32'(flat_b), 32'h1239);
        check("newbatch_sc",   32'(sc_b),   0);
        rd_idx_b = 2'd0;
        #1 check("newbatch_rd0", 32'(rd_data_b), 9);

        repeat (3) @(negedge clk);
        check("queue_a_drained", 32'(q_a.size()), 0);
        check("queue_b_drained", 32'(q_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
